free_list: RTL

FREE_LIST -- requirements
Module: free_list

---
 rtl/free_list_pkg.sv | 19 +
 rtl/free_list.sv | 96 +++++++++
 2 files changed

// File: rtl/free_list_pkg.sv
// Shared processor package: physical register file, free list and ROB sizing,
// plus the physical tag type used by rename, ROB and the free list.
package free_list_pkg;

  localparam int PRF_NUM_P  = 64;
  localparam int ARF_NUM_P  = 32;
  localparam int FL_DEPTH_P = PRF_NUM_P - ARF_NUM_P;
  localparam int TAG_W      = $clog2(PRF_NUM_P);

  localparam int FL_IDX_W = $clog2(FL_DEPTH_P);
  localparam int FL_PTR_W = FL_IDX_W + 1;

  localparam int ROB_DEPTH = 32;
  localparam int ROB_IDX_W = $clog2(ROB_DEPTH);
  localparam int ROB_PTR_W = ROB_IDX_W + 1;

  typedef logic [TAG_W-1:0] prf_tag_t;

endpackage

// File: rtl/free_list.sv
// Physical-register free list: circular FIFO of free tags, refilled by ROB retire,
// drained by dispatch, restored to full on flush. Optional FL_BYPASS_EN macro
// forwards a retiring tag straight to dispatch when the list is empty.
module free_list
  import free_list_pkg::*;
#(
  parameter int FL_DEPTH = FL_DEPTH_P,
  parameter int PRF_NUM  = PRF_NUM_P
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             fl_dispatch_en_i,
  input  logic [TAG_W-1:0] rob2fl_tag_i,
  input  logic             rob2fl_tag_vld_i,
  input  logic             fl_flush_i,
  output logic [TAG_W-1:0] fl_tag_o,
  output logic             fl_empty_o,
  output logic [FL_PTR_W-1:0] fl_cnt_o
);

  localparam int IDX_W = FL_IDX_W;
  localparam int PTR_W = FL_PTR_W;

  prf_tag_t         entry_r [FL_DEPTH];
  logic [PTR_W-1:0] head_r;
  logic [PTR_W-1:0] tail_r;
  logic [PTR_W-1:0] head_nxt;
  logic [PTR_W-1:0] tail_nxt;

  logic empty;
  logic full;
  logic bypass;
  logic push;
  logic pop;

  assign empty = (head_r == tail_r);
  assign full  = (head_r[IDX_W-1:0] == tail_r[IDX_W-1:0]) &&
                 (head_r[PTR_W-1] != tail_r[PTR_W-1]);

`ifdef FL_BYPASS_EN
  // Retiring tag goes straight to dispatch; list state is left untouched.
  assign bypass = empty && rob2fl_tag_vld_i && fl_dispatch_en_i;
`else
  assign bypass = 1'b0;
`endif

  assign push = rob2fl_tag_vld_i && !full && !bypass;
  assign pop  = fl_dispatch_en_i && !empty && !bypass;

  always_comb begin
    tail_nxt = tail_r + {{(PTR_W-1){1'b0}}, push};
    head_nxt = head_r;
    if (fl_flush_i) begin
      // Head lands one full lap behind tail, so every non-architectural tag is free.
      head_nxt = {~tail_nxt[PTR_W-1], tail_nxt[PTR_W-2:0]};
    end else if (pop) begin
      head_nxt = head_r + {{(PTR_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_r <= '0;
      tail_r <= {1'b1, {(PTR_W-1){1'b0}}};
      for (int i = 0; i < FL_DEPTH; i++) begin
        entry_r[i] <= TAG_W'(PRF_NUM - FL_DEPTH + i);
      end
    end else begin
      head_r <= head_nxt;
      tail_r <= tail_nxt;
      if (push) begin
        entry_r[tail_r[IDX_W-1:0]] <= rob2fl_tag_i;
      end
    end
  end

  always_comb begin
    fl_tag_o   = entry_r[head_r[IDX_W-1:0]];
    fl_empty_o = empty;
    if (bypass) begin
      fl_tag_o   = rob2fl_tag_i;
      fl_empty_o = 1'b0;
    end
  end

  assign fl_cnt_o = full ? PTR_W'(FL_DEPTH) : (tail_r - head_r);

  // A retire into a full list means ROB and free list disagree on tag ownership.
  always @(posedge clock) begin
    if (!reset) begin
      assert (!(rob2fl_tag_vld_i && full))
        else $error("free_list: tag %0d returned while list full, dropped", rob2fl_tag_i);
    end
  end

endmodule
